// File: rtl/cache_pkg.sv
// cache_pkg: shared widths, AXI response codes and the read-FSM state type
// for the cache subsystem and its AXI4-Lite backing memory.
package cache_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } rd_state_t;

endpackage

// File: rtl/axi_mem_array.sv
// axi_mem_array: MEM_DEPTH x DATA_WIDTH word array.
//   clk   in   clock
//   we    in   write enable (one word per cycle)
//   waddr in   write word index
//   wdata in   write data
//   wstrb in   byte enables for the write
//   raddr in   read word index
//   rdata out  read data, combinational from raddr
// Contents are not reset. The read port is asynchronous so the parent can
// register it in the same edge a write commits, which gives read-before-write.
module axi_mem_array #(
    parameter int DATA_WIDTH = cache_pkg::DATA_WIDTH,
    parameter int MEM_DEPTH  = 1024,
    localparam int DATA_BYTES = DATA_WIDTH / 8,
    localparam int IDX_W      = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_BYTES-1:0] wstrb,
    input  logic [IDX_W-1:0]      raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DATA_BYTES; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axi_lite_backing_mem.sv
// axi_lite_backing_mem: AXI4-Lite slave memory model standing in for main
// memory behind the cache's AXI4-Lite master port.
//   aclk_i / arstn_i        clock, asynchronous active-low reset
//   aw* (valid/ready/addr/prot)   write address channel
//   w*  (valid/ready/data/strb)   write data channel
//   b*  (valid/ready/resp)        write response channel
//   ar* (valid/ready/addr/prot)   read address channel
//   r*  (valid/ready/data/resp)   read data channel
// One outstanding write (AW and W in any order), one outstanding read with
// RD_LATENCY cycles from AR handshake to rvalid. Out-of-range accesses get
// SLVERR. Build option AXI_MEM_PROT_CHK_EN: prot[1]=1 (non-secure) also
// gets SLVERR; otherwise prot is ignored.
module axi_lite_backing_mem
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = cache_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = cache_pkg::DATA_WIDTH,
    parameter int DATA_BYTES = DATA_WIDTH / 8,
    parameter int MEM_DEPTH  = 1024,
    parameter int RD_LATENCY = 2
) (
    input  logic                  aclk_i,
    input  logic                  arstn_i,
    output logic                  awready_o,
    input  logic                  awvalid_i,
    input  logic [ADDR_WIDTH-1:0] awaddr_i,
    input  logic [2:0]            awprot_i,
    output logic                  wready_o,
    input  logic                  wvalid_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [DATA_BYTES-1:0] wstrb_i,
    output logic                  bvalid_o,
    output logic [1:0]            bresp_o,
    input  logic                  bready_i,
    output logic                  arready_o,
    input  logic                  arvalid_i,
    input  logic [ADDR_WIDTH-1:0] araddr_i,
    input  logic [2:0]            arprot_i,
    output logic                  rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [1:0]            rresp_o,
    input  logic                  rready_i
);

    localparam int OFF_W = $clog2(DATA_BYTES);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_DEPTH * DATA_BYTES);
    localparam logic [3:0] LAT_M1 = 4'(RD_LATENCY - 1);

    function automatic logic access_err(input logic [ADDR_WIDTH-1:0] addr,
                                        input logic                  prot_err);
        return ({1'b0, addr} >= MEM_BYTES) || prot_err;
    endfunction

    logic aw_prot_err;
    logic ar_prot_err;
    logic unused_prot;
`ifdef AXI_MEM_PROT_CHK_EN
    assign aw_prot_err = awprot_i[1];
    assign ar_prot_err = arprot_i[1];
`else
    assign aw_prot_err = 1'b0;
    assign ar_prot_err = 1'b0;
`endif
    assign unused_prot = ^{awprot_i, arprot_i};

    // Held low through reset and for the first edge after release so no
    // ready is visible while the block is coming out of reset.
    logic en_q;

    // ---------------- write path ----------------
    logic                  aw_vld_q, w_vld_q, aw_err_q;
    logic [IDX_W-1:0]      aw_idx_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [DATA_BYTES-1:0] w_strb_q;
    logic                  bvalid_q;
    logic [1:0]            bresp_q;
    logic                  aw_hs, w_hs, commit;

    assign awready_o = en_q && !aw_vld_q && !bvalid_q;
    assign wready_o  = en_q && !w_vld_q  && !bvalid_q;
    assign aw_hs     = awvalid_i && awready_o;
    assign w_hs      = wvalid_i  && wready_o;
    assign commit    = aw_vld_q && w_vld_q;
    assign bvalid_o  = bvalid_q;
    assign bresp_o   = bresp_q;

    always_ff @(posedge aclk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            en_q     <= 1'b0;
            aw_vld_q <= 1'b0;
            w_vld_q  <= 1'b0;
            aw_err_q <= 1'b0;
            bvalid_q <= 1'b0;
            bresp_q  <= AXI_RESP_OKAY;
        end else begin
            en_q <= 1'b1;
            if (aw_hs) begin
                aw_vld_q <= 1'b1;
                aw_err_q <= access_err(awaddr_i, aw_prot_err);
            end
            if (w_hs) begin
                w_vld_q <= 1'b1;
            end
            if (commit) begin
                aw_vld_q <= 1'b0;
                w_vld_q  <= 1'b0;
                bvalid_q <= 1'b1;
                bresp_q  <= aw_err_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            end else if (bvalid_q && bready_i) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge aclk_i) begin
        if (aw_hs) begin
            aw_idx_q <= awaddr_i[OFF_W +: IDX_W];
        end
        if (w_hs) begin
            w_data_q <= wdata_i;
            w_strb_q <= wstrb_i;
        end
    end

    // ---------------- read path ----------------
    rd_state_t             state_q, state_d;
    logic [3:0]            rd_cnt_q;
    logic [IDX_W-1:0]      ar_idx_q;
    logic                  ar_err_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic                  ar_hs, rd_sample, rd_err;
    logic [IDX_W-1:0]      rd_idx;
    logic [DATA_WIDTH-1:0] mem_rdata;

    assign arready_o = en_q && (state_q == R_IDLE);
    assign ar_hs     = arvalid_i && arready_o;
    assign rvalid_o  = (state_q == R_RESP);
    assign rdata_o   = rdata_q;
    assign rresp_o   = rresp_q;

    // With RD_LATENCY=1 the array is sampled on the handshake edge itself,
    // straight from the AR bus; otherwise from the latched address.
    assign rd_idx = (state_q == R_IDLE) ? araddr_i[OFF_W +: IDX_W] : ar_idx_q;
    assign rd_err = (state_q == R_IDLE) ? access_err(araddr_i, ar_prot_err) : ar_err_q;

    always_comb begin
        state_d   = state_q;
        rd_sample = 1'b0;
        case (state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    if (RD_LATENCY == 1) begin
                        state_d   = R_RESP;
                        rd_sample = 1'b1;
                    end else begin
                        state_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                // Counter reaches 0 on this edge: sample now so rvalid
                // lands exactly RD_LATENCY cycles after the handshake.
                if (rd_cnt_q <= 4'd1) begin
                    state_d   = R_RESP;
                    rd_sample = 1'b1;
                end
            end
            R_RESP: begin
                if (rready_i) begin
                    state_d = R_IDLE;
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q  <= R_IDLE;
            rd_cnt_q <= 4'd0;
            ar_err_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= AXI_RESP_OKAY;
        end else begin
            state_q <= state_d;
            if (ar_hs) begin
                rd_cnt_q <= LAT_M1;
                ar_err_q <= rd_err;
            end else if (state_q == R_WAIT) begin
                rd_cnt_q <= rd_cnt_q - 4'd1;
            end
            if (rd_sample) begin
                rdata_q <= rd_err ? '0 : mem_rdata;
                rresp_q <= rd_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            end
        end
    end

    always_ff @(posedge aclk_i) begin
        if (ar_hs) begin
            ar_idx_q <= araddr_i[OFF_W +: IDX_W];
        end
    end

    axi_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_array (
        .clk   (aclk_i),
        .we    (commit && !aw_err_q),
        .waddr (aw_idx_q),
        .wdata (w_data_q),
        .wstrb (w_strb_q),
        .raddr (rd_idx),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_axi_lite_backing_mem.sv
module tb_axi_lite_backing_mem;

    localparam int RD_LAT = 2;
    localparam int NWORDS = 16;

    logic        aclk = 1'b0;
    logic        arstn;
    logic        awready, awvalid, wready, wvalid, bvalid, bready;
    logic        arready, arvalid, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int n_chk  = 0;
    int n_pass = 0;

    axi_lite_backing_mem #(
        .MEM_DEPTH  (1024),
        .RD_LATENCY (RD_LAT)
    ) dut (
        .aclk_i    (aclk),
        .arstn_i   (arstn),
        .awready_o (awready),
        .awvalid_i (awvalid),
        .awaddr_i  (awaddr),
        .awprot_i  (awprot),
        .wready_o  (wready),
        .wvalid_i  (wvalid),
        .wdata_i   (wdata),
        .wstrb_i   (wstrb),
        .bvalid_o  (bvalid),
        .bresp_o   (bresp),
        .bready_i  (bready),
        .arready_o (arready),
        .arvalid_i (arvalid),
        .araddr_i  (araddr),
        .arprot_i  (arprot),
        .rvalid_o  (rvalid),
        .rdata_o   (rdata),
        .rresp_o   (rresp),
        .rready_i  (rready)
    );

    always #5 aclk = ~aclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic wait_b(output logic [1:0] resp);
        int n = 0;
        while (!bvalid && n < 20) begin
            tick();
            n++;
        end
        chk("b_wait_bound", 32'(n < 20), 32'd1);
        resp   = bresp;
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [2:0] prot, input int aw_dly, input int w_dly,
                            output logic [1:0] resp);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        int cyc = 0;
        while (!(aw_done && w_done) && cyc < 50) begin
            awvalid = !aw_done && cyc >= aw_dly;
            awaddr  = a;
            awprot  = prot;
            wvalid  = !w_done && cyc >= w_dly;
            wdata   = d;
            wstrb   = s;
            aw_hs   = awvalid && awready;
            w_hs    = wvalid && wready;
            tick();
            if (aw_hs) aw_done = 1;
            if (w_hs)  w_done  = 1;
            cyc++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        chk("aw_w_accept_bound", 32'(aw_done && w_done), 32'd1);
        wait_b(resp);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [2:0] prot,
                           output logic [31:0] d, output logic [1:0] resp, output int lat);
        int n = 0;
        arvalid = 1'b1;
        araddr  = a;
        arprot  = prot;
        while (!arready && n < 50) begin
            tick();
            n++;
        end
        chk("ar_accept_bound", 32'(n < 50), 32'd1);
        tick();  // handshake cycle ends here
        arvalid = 1'b0;
        lat = 1;
        while (!rvalid && lat < 50) begin
            tick();
            lat++;
        end
        d      = rdata;
        resp   = rresp;
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    typedef struct {
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  exp_bresp;
        logic [31:0] raddr;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_rresp;
    } vec_t;

    vec_t        vecs[11];
    logic [31:0] ref_mem[NWORDS];

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;

        vecs[0]  = '{32'h10,   32'hDEADBEEF, 4'hF, 2'b00, 32'h10,   32'hDEADBEEF, 2'b00};
        vecs[1]  = '{32'h20,   32'hFFFFFFFF, 4'hF, 2'b00, 32'h20,   32'hFFFFFFFF, 2'b00};
        vecs[2]  = '{32'h24,   32'h12345678, 4'hF, 2'b00, 32'h24,   32'h12345678, 2'b00};
        vecs[3]  = '{32'h26,   32'hCAFEF00D, 4'hF, 2'b00, 32'h24,   32'hCAFEF00D, 2'b00};
        vecs[4]  = '{32'h0,    32'h55AA55AA, 4'hF, 2'b00, 32'h0,    32'h55AA55AA, 2'b00};
        vecs[5]  = '{32'h1000, 32'h01020304, 4'hF, 2'b10, 32'h0,    32'h55AA55AA, 2'b00};
        vecs[6]  = '{32'h1004, 32'h01020304, 4'hF, 2'b10, 32'h1000, 32'h00000000, 2'b10};
        vecs[7]  = '{32'hFFC,  32'hAABBCCDD, 4'hF, 2'b00, 32'hFFF,  32'hAABBCCDD, 2'b00};
        vecs[8]  = '{32'h30,   32'h11111111, 4'hF, 2'b00, 32'h30,   32'h11111111, 2'b00};
        vecs[9]  = '{32'h30,   32'h22222222, 4'h0, 2'b00, 32'h30,   32'h11111111, 2'b00};
        vecs[10] = '{32'h30,   32'h99887766, 4'h8, 2'b00, 32'h30,   32'h99111111, 2'b00};

        arstn = 1'b0;
        {awvalid, wvalid, bready, arvalid, rready} = '0;
        awaddr = '0; wdata = '0; araddr = '0; awprot = '0; arprot = '0; wstrb = '0;

        // Reset state
        repeat (2) tick();
        chk("rst_awready", 32'(awready), 32'd0);
        chk("rst_wready",  32'(wready),  32'd0);
        chk("rst_arready", 32'(arready), 32'd0);
        chk("rst_bvalid",  32'(bvalid),  32'd0);
        chk("rst_rvalid",  32'(rvalid),  32'd0);
        chk("rst_bresp",   32'(bresp),   32'd0);
        chk("rst_rresp",   32'(rresp),   32'd0);
        chk("rst_rdata",   rdata,        32'd0);
        #2 arstn = 1'b1;
        tick();
        chk("post_rst_arready", 32'(arready), 32'd1);
        chk("post_rst_awready", 32'(awready), 32'd1);

        // Table-driven write / readback
        for (int i = 0; i < 11; i++) begin
            do_write(vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb, 3'b000, 0, 0, r);
            chk($sformatf("vec%0d_bresp", i), 32'(r), 32'(vecs[i].exp_bresp));
            do_read(vecs[i].raddr, 3'b000, d, r, lat);
            chk($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_rresp", i), 32'(r), 32'(vecs[i].exp_rresp));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(RD_LAT));
        end

        // W three cycles ahead of AW, partial strobes, then B backpressure
        wvalid = 1'b1; wdata = 32'h11223344; wstrb = 4'b0101;
        chk("seqA_wready_idle", 32'(wready), 32'd1);
        tick();
        wvalid = 1'b0;
        chk("seqA_wready_latched", 32'(wready), 32'd0);
        chk("seqA_awready_open", 32'(awready), 32'd1);
        repeat (2) tick();
        awvalid = 1'b1; awaddr = 32'h20; awprot = 3'b000;
        tick();
        awvalid = 1'b0;
        chk("seqA_awready_busy", 32'(awready), 32'd0);
        chk("seqA_wready_busy",  32'(wready),  32'd0);
        tick();
        chk("seqA_bvalid", 32'(bvalid), 32'd1);
        awvalid = 1'b1; awaddr = 32'h34;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("seqA_hold%0d_bvalid", k), 32'(bvalid), 32'd1);
            chk($sformatf("seqA_hold%0d_bresp", k), 32'(bresp), 32'd0);
            chk($sformatf("seqA_hold%0d_awready", k), 32'(awready), 32'd0);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("seqA_bvalid_cleared", 32'(bvalid), 32'd0);
        chk("seqA_awready_reopen", 32'(awready), 32'd1);
        tick();
        awvalid = 1'b0;
        chk("seqA_second_aw_taken", 32'(awready), 32'd0);
        wvalid = 1'b1; wdata = 32'h0BADF00D; wstrb = 4'hF;
        tick();
        wvalid = 1'b0;
        wait_b(r);
        chk("seqA_second_bresp", 32'(r), 32'd0);
        do_read(32'h20, 3'b000, d, r, lat);
        chk("seqA_merge_rdata", d, 32'hFF22FF44);
        do_read(32'h34, 3'b000, d, r, lat);
        chk("seqA_second_rdata", d, 32'h0BADF00D);

        // Write commit and read sample on the same edge at 0x40
        do_write(32'h40, 32'hA5A5A5A5, 4'hF, 3'b000, 0, 0, r);
        awvalid = 1'b1; awaddr = 32'h40; wvalid = 1'b1; wdata = 32'h5A5A5A5A; wstrb = 4'hF;
        arvalid = 1'b1; araddr = 32'h40; arprot = 3'b000;
        chk("seqB_all_ready", 32'(awready && wready && arready), 32'd1);
        tick();
        {awvalid, wvalid, arvalid} = '0;
        tick();
        chk("seqB_bvalid", 32'(bvalid), 32'd1);
        chk("seqB_rvalid", 32'(rvalid), 32'd1);
        chk("seqB_old_data", rdata, 32'hA5A5A5A5);
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;
        do_read(32'h40, 3'b000, d, r, lat);
        chk("seqB_new_data", d, 32'h5A5A5A5A);

        // Protection bit handling
        do_write(32'h10, 32'h0, 4'hF, 3'b010, 0, 0, r);
`ifdef AXI_MEM_PROT_CHK_EN
        chk("prot_bresp", 32'(r), 32'd2);
        do_read(32'h10, 3'b010, d, r, lat);
        chk("prot_rresp", 32'(r), 32'd2);
        chk("prot_rdata", d, 32'd0);
        do_read(32'h10, 3'b000, d, r, lat);
        chk("prot_untouched", d, 32'hDEADBEEF);
`else
        chk("prot_bresp", 32'(r), 32'd0);
        do_read(32'h10, 3'b010, d, r, lat);
        chk("prot_rresp", 32'(r), 32'd0);
        chk("prot_rdata", d, 32'd0);
`endif

        // Reset while the read is waiting
        arvalid = 1'b1; araddr = 32'h24; arprot = 3'b000;
        tick();
        arvalid = 1'b0;
        arstn = 1'b0;
        #1;
        chk("seqC_arready_in_rst", 32'(arready), 32'd0);
        chk("seqC_rvalid_in_rst",  32'(rvalid),  32'd0);
        tick();
        chk("seqC_rvalid_in_rst2", 32'(rvalid), 32'd0);
        #3 arstn = 1'b1;
        tick();
        chk("seqC_arready_release", 32'(arready), 32'd1);
        chk("seqC_rvalid_release",  32'(rvalid),  32'd0);
        tick();
        chk("seqC_no_late_rvalid", 32'(rvalid), 32'd0);

        // Randomized traffic against a word-array model
        for (int i = 0; i < NWORDS; i++) begin
            ref_mem[i] = $urandom;
            do_write(32'(i * 4), ref_mem[i], 4'hF, 3'b000, 0, 0, r);
            chk("rnd_init_bresp", 32'(r), 32'd0);
        end
        for (int t = 0; t < 150; t++) begin
            logic [31:0] a, wd, exp_d;
            logic [3:0]  s;
            bit          oor;
            int          idx;
            oor = ($urandom_range(0, 7) == 0);
            a   = oor ? 32'h1000 + 32'($urandom_range(0, 1023)) :
                        32'($urandom_range(0, NWORDS * 4 - 1));
            idx = int'(a / 4);
            if ($urandom_range(0, 1) == 1) begin
                wd = $urandom;
                s  = 4'($urandom);
                do_write(a, wd, s, 3'b000, $urandom_range(0, 3), $urandom_range(0, 3), r);
                chk($sformatf("rnd%0d_bresp", t), 32'(r), oor ? 32'd2 : 32'd0);
                if (!oor) begin
                    for (int b = 0; b < 4; b++)
                        if (s[b]) ref_mem[idx][b*8 +: 8] = wd[b*8 +: 8];
                end
            end else begin
                do_read(a, 3'b000, d, r, lat);
                exp_d = oor ? 32'd0 : ref_mem[idx];
                chk($sformatf("rnd%0d_rdata", t), d, exp_d);
                chk($sformatf("rnd%0d_rresp", t), 32'(r), oor ? 32'd2 : 32'd0);
                chk($sformatf("rnd%0d_latency", t), 32'(lat), 32'(RD_LAT));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/axi_lite_backing_mem.md
Name: axi_lite_backing_mem

Overview:
- AXI4-Lite slave memory model. It sits directly downstream of the cache's AXI4-Lite master port (m_aw*/m_w*/m_b*/m_ar*/m_r*).
- Serves line refills (reads) and write-back buffer drains (writes) from a word-addressed array.
- Read latency is configurable. Address/protection errors return SLVERR.
- Used as the main-memory stand-in in system simulation and FPGA bring-up.

Parameters:
- ADDR_WIDTH, cache_pkg::ADDR_WIDTH (32): address bus width.
- DATA_WIDTH, cache_pkg::DATA_WIDTH (32): data bus width.
- DATA_BYTES, DATA_WIDTH/8: strobe width.
- MEM_DEPTH, 1024: number of DATA_WIDTH words; power of two, ≥2.
- RD_LATENCY, 2: cycles from AR handshake to first rvalid; range 1..15.

Ports:
- aclk_i  in  1  clock
- arstn_i  in  1  asynchronous active-low reset
- awready_o  out  1  write address ready
- awvalid_i  in  1  write address valid
- awaddr_i  in  ADDR_WIDTH  write byte address
- awprot_i  in  3  write protection
- wready_o  out  1  write data ready
- wvalid_i  in  1  write data valid
- wdata_i  in  DATA_WIDTH  write data
- wstrb_i  in  DATA_BYTES  byte strobes
- bvalid_o  out  1  write response valid
- bresp_o  out  2  write response
- bready_i  in  1  write response ready
- arready_o  out  1  read address ready
- arvalid_i  in  1  read address valid
- araddr_i  in  ADDR_WIDTH  read byte address
- arprot_i  in  3  read protection
- rvalid_o  out  1  read data valid
- rdata_o  out  DATA_WIDTH  read data
- rresp_o  out  2  read response
- rready_i  in  1  read data ready

Behaviour:
- Reset (async assert, sync release via upstream rst_sync): all valids/readies 0, bresp_o/rresp_o 2'b00, rdata_o 0, all latches cleared. Array contents are not reset.
- Address decode:
  - word index = addr[$clog2(DATA_BYTES) +: $clog2(MEM_DEPTH)]; low byte-offset bits are ignored.
  - Out of range when addr ≥ MEM_DEPTH*DATA_BYTES.
- Write path: AW and W are independent, one outstanding write.
  - awready_o = no AW latched and B channel idle.
  - wready_o = no W latched and B channel idle.
  - AW and W may arrive in either order or in the same cycle.
  - The cycle after both are latched: commit. Write bytes where wstrb_i=1 unless error, clear both latches, set bvalid_o.
  - bresp_o = 2'b00 OKAY, or 2'b10 SLVERR on range error (array untouched).
  - bvalid_o holds with stable bresp until bready_i; no new AW/W is accepted while bvalid_o=1.
  - wstrb=0 with OKAY writes nothing.
- Read path FSM, states R_IDLE, R_WAIT, R_RESP:
  - R_IDLE: arready_o=1. On arvalid_i: latch address/prot, load counter=RD_LATENCY-1, go to R_WAIT; if RD_LATENCY=1, go straight to R_RESP.
  - R_WAIT: arready_o=0; decrement counter; at 0, sample array into rdata_o, set rvalid_o, go to R_RESP.
  - R_RESP: rvalid_o=1, data/resp stable until rready_i. On handshake go to R_IDLE; the next AR can be accepted the following cycle.
  - Error reads: rdata_o=0, rresp_o=2'b10.
- Latency: AR handshake at cycle N → rvalid_o at N+RD_LATENCY.
- Simultaneous write commit and read sample on the same word: read returns the pre-write data (read-before-write). Read and write channels otherwise run concurrently and independently.
- Reset mid-transaction: all in-flight transactions are dropped and no response is issued. A write not yet committed is lost.

Optional Feature:
- Macro AXI_MEM_PROT_CHK_EN.
- Defined: a transaction whose prot[1]=1 (non-secure) gets SLVERR. Writes are suppressed; reads return 0. This applies independently of the range check.
- Undefined: awprot_i/arprot_i are ignored; only the range check produces SLVERR.

Decomposition:
- cache_pkg gets:
  - AXI_RESP_OKAY=2'b00 and AXI_RESP_SLVERR=2'b10;
  - a read-FSM state enum rd_state_t.
- Width parameters keep cache_pkg defaults.
- One sub-module, axi_mem_array:
  - MEM_DEPTH×DATA_WIDTH;
  - one byte-strobed synchronous write port;
  - one asynchronous read port, registered by the parent.
- The handshake logic stays in the top of the block.

Test Plan:
- Write 0xDEADBEEF to 0x10 with strb 4'hF, then read 0x10 with RD_LATENCY=2 → bresp 00; rvalid exactly 2 cycles after AR handshake; rdata 0xDEADBEEF, rresp 00.
- W sent 3 cycles before AW (addr 0x20, data 0x11223344, strb 4'b0101) over a prior 0xFFFFFFFF → readback 0xFF22FF44; awready/wready both 0 until bready.
- Hold bready_i=0 for 5 cycles → bvalid_o and bresp stable; second AW not accepted until 1 cycle after B handshake.
- Write to 0x1000 (MEM_DEPTH=1024, 32-bit) → bresp 10, array unchanged. Read 0x1000 → rresp 10, rdata 0.
- Same-cycle write commit and read sample at 0x40 (old 0xA5A5A5A5, new 0x5A5A5A5A) → read returns 0xA5A5A5A5; next read returns 0x5A5A5A5A.
- arstn_i low while in R_WAIT → rvalid_o stays 0, arready_o=0 during reset and 1 the first cycle after release.
- With AXI_MEM_PROT_CHK_EN, read with arprot=3'b010 → rresp 10.
